// File: rtl/demux122_stream.sv
// demux122_stream: registered 1-to-2 stream demultiplexer with valid/ready
// handshaking. Each accepted input word is steered by IN_SEL into one of two
// small per-destination FIFOs, so a stalled consumer only blocks new words
// aimed at its own FIFO, never words already queued for the other one.
//
// Optional feature macro: DEMUX_STATS_EN
//   When defined, adds OUT0_XFERS / OUT1_XFERS (16-bit pop counters that
//   reset to 0 and wrap). When undefined, those ports and counters vanish.
module demux122_stream #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_SEL,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT0_DATA,
    output logic             OUT0_VALID,
    input  logic             OUT0_READY,
    output logic [WIDTH-1:0] OUT1_DATA,
    output logic             OUT1_VALID,
    input  logic             OUT1_READY
`ifdef DEMUX_STATS_EN
    ,
    output logic [15:0]      OUT0_XFERS,
    output logic [15:0]      OUT1_XFERS
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Per-FIFO state; index 0 feeds OUT0, index 1 feeds OUT1.
    logic [WIDTH-1:0] mem_q    [2][DEPTH];
    logic [WIDTH-1:0] mem_d    [2][DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [2];
    logic [PTR_W-1:0] wr_ptr_d [2];
    logic [PTR_W-1:0] rd_ptr_q [2];
    logic [PTR_W-1:0] rd_ptr_d [2];
    logic [CNT_W-1:0] count_q  [2];
    logic [CNT_W-1:0] count_d  [2];

    // Handshake qualifiers, one bit per FIFO.
    logic [1:0] full;
    logic [1:0] out_valid;
    logic [1:0] out_ready;
    logic [1:0] push_en;
    logic [1:0] pop_en;
    logic       push;

    assign out_ready = {OUT1_READY, OUT0_READY};

    // Status flags come from the registered count only, so a full FIFO being
    // drained this cycle still refuses a new word until the next cycle.
    always_comb begin
        full      = '0;
        out_valid = '0;
        for (int x = 0; x < 2; x++) begin
            full[x]      = (count_q[x] == CNT_W'(DEPTH));
            out_valid[x] = (count_q[x] != '0);
        end
    end

    // Ready depends only on the targeted FIFO, never on IN_VALID, so the
    // producer may retarget IN_SEL while holding a word.
    always_comb begin
        IN_READY = ~full[IN_SEL];
        push     = IN_VALID & IN_READY;
        push_en  = '0;
        pop_en   = '0;
        for (int x = 0; x < 2; x++) begin
            push_en[x] = push & (IN_SEL == 1'(x));
            pop_en[x]  = out_valid[x] & out_ready[x];
        end
    end

    // Next-state for both FIFOs: write at the write pointer on a push,
    // advance the read pointer on a pop, and keep count steady when both
    // happen together. Pointers wrap naturally since DEPTH is a power of 2.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int x = 0; x < 2; x++) begin
            if (push_en[x]) begin
                mem_d[x][wr_ptr_q[x]] = IN_DATA;
                wr_ptr_d[x]           = wr_ptr_q[x] + PTR_W'(1);
            end
            if (pop_en[x]) begin
                rd_ptr_d[x] = rd_ptr_q[x] + PTR_W'(1);
            end
            case ({push_en[x], pop_en[x]})
                2'b10:   count_d[x] = count_q[x] + CNT_W'(1);
                2'b01:   count_d[x] = count_q[x] - CNT_W'(1);
                default: count_d[x] = count_q[x];
            endcase
        end
    end

    // FIFO state registers; reset discards anything in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int x = 0; x < 2; x++) begin
                wr_ptr_q[x] <= '0;
                rd_ptr_q[x] <= '0;
                count_q[x]  <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[x][e] <= '0;
                end
            end
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head-of-FIFO outputs; data is forced to zero while a FIFO is empty so
    // stale storage never leaks onto an idle output.
    always_comb begin
        OUT0_VALID = out_valid[0];
        OUT1_VALID = out_valid[1];
        OUT0_DATA  = out_valid[0] ? mem_q[0][rd_ptr_q[0]] : '0;
        OUT1_DATA  = out_valid[1] ? mem_q[1][rd_ptr_q[1]] : '0;
    end

`ifdef DEMUX_STATS_EN
    logic [15:0] xfers_q [2];
    logic [15:0] xfers_d [2];

    // Completed-pop counters, wrapping from 0xFFFF back to 0.
    always_comb begin
        xfers_d = xfers_q;
        for (int x = 0; x < 2; x++) begin
            if (pop_en[x]) begin
                xfers_d[x] = xfers_q[x] + 16'd1;
            end
        end
    end

    // Counter registers; an asynchronous reset wins over a same-cycle pop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            xfers_q[0] <= '0;
            xfers_q[1] <= '0;
        end else begin
            xfers_q <= xfers_d;
        end
    end

    assign OUT0_XFERS = xfers_q[0];
    assign OUT1_XFERS = xfers_q[1];
`endif

endmodule

// File: tb/tb_demux122_stream.sv
// tb_demux122_stream: table-driven directed bench for demux122_stream.
// Each table row holds one cycle of inputs plus the outputs expected just
// before the following rising edge. Reset corners are hand-written sequences.
module tb_demux122_stream;

    logic       CLK;
    logic       RST_N;
    logic [3:0] IN_DATA;
    logic       IN_SEL;
    logic       IN_VALID;
    logic       IN_READY;
    logic [3:0] OUT0_DATA;
    logic       OUT0_VALID;
    logic       OUT0_READY;
    logic [3:0] OUT1_DATA;
    logic       OUT1_VALID;
    logic       OUT1_READY;
`ifdef DEMUX_STATS_EN
    logic [15:0] OUT0_XFERS;
    logic [15:0] OUT1_XFERS;
`endif

    int vec_count  = 0;
    int miscompare = 0;
    int exp_x0     = 0;
    int exp_x1     = 0;

    typedef struct {
        logic       sel;
        logic [3:0] data;
        logic       valid;
        logic       r0;
        logic       r1;
        logic       e_rdy;
        logic       e_v0;
        logic [3:0] e_d0;
        logic       e_v1;
        logic [3:0] e_d1;
    } vec_t;

    vec_t vecs[$];

    demux122_stream #(.WIDTH(4), .DEPTH(2)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .IN_DATA    (IN_DATA),
        .IN_SEL     (IN_SEL),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .OUT0_DATA  (OUT0_DATA),
        .OUT0_VALID (OUT0_VALID),
        .OUT0_READY (OUT0_READY),
        .OUT1_DATA  (OUT1_DATA),
        .OUT1_VALID (OUT1_VALID),
        .OUT1_READY (OUT1_READY)
`ifdef DEMUX_STATS_EN
        ,
        .OUT0_XFERS (OUT0_XFERS),
        .OUT1_XFERS (OUT1_XFERS)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic addVec(input logic sel, input logic [3:0] data, input logic valid,
                          input logic r0, input logic r1, input logic e_rdy,
                          input logic e_v0, input logic [3:0] e_d0,
                          input logic e_v1, input logic [3:0] e_d1);
        vec_t v;
        v.sel = sel; v.data = data; v.valid = valid; v.r0 = r0; v.r1 = r1;
        v.e_rdy = e_rdy; v.e_v0 = e_v0; v.e_d0 = e_d0; v.e_v1 = e_v1; v.e_d1 = e_d1;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs after the falling edge, then settle until
    // just before the next rising edge.
    task automatic applyStimulus(input logic sel, input logic [3:0] data, input logic valid,
                                 input logic r0, input logic r1);
        @(negedge CLK);
        IN_SEL     = sel;
        IN_DATA    = data;
        IN_VALID   = valid;
        OUT0_READY = r0;
        OUT1_READY = r1;
        #4;
    endtask

    task automatic checkOutput(input string tag, input logic e_rdy,
                               input logic e_v0, input logic [3:0] e_d0,
                               input logic e_v1, input logic [3:0] e_d1);
        vec_count++;
        if (IN_READY !== e_rdy) begin
            miscompare++;
            $display("[TB] FAIL %s IN_READY: got %b expected %b", tag, IN_READY, e_rdy);
        end
        if (OUT0_VALID !== e_v0) begin
            miscompare++;
            $display("[TB] FAIL %s OUT0_VALID: got %b expected %b", tag, OUT0_VALID, e_v0);
        end
        if (OUT0_DATA !== e_d0) begin
            miscompare++;
            $display("[TB] FAIL %s OUT0_DATA: got %h expected %h", tag, OUT0_DATA, e_d0);
        end
        if (OUT1_VALID !== e_v1) begin
            miscompare++;
            $display("[TB] FAIL %s OUT1_VALID: got %b expected %b", tag, OUT1_VALID, e_v1);
        end
        if (OUT1_DATA !== e_d1) begin
            miscompare++;
            $display("[TB] FAIL %s OUT1_DATA: got %h expected %h", tag, OUT1_DATA, e_d1);
        end
    endtask

`ifdef DEMUX_STATS_EN
    task automatic checkXfers(input string tag, input int e0, input int e1);
        vec_count++;
        if (OUT0_XFERS !== 16'(e0)) begin
            miscompare++;
            $display("[TB] FAIL %s OUT0_XFERS: got %0d expected %0d", tag, OUT0_XFERS, e0);
        end
        if (OUT1_XFERS !== 16'(e1)) begin
            miscompare++;
            $display("[TB] FAIL %s OUT1_XFERS: got %0d expected %0d", tag, OUT1_XFERS, e1);
        end
    endtask
`endif

    initial begin
        // Columns: sel data valid r0 r1 | rdy v0 d0 v1 d1
        // Single route to OUT1 with both consumers stalled, then drain.
        addVec(1, 4'hA, 1, 0, 0,  1, 0, 4'h0, 0, 4'h0);
        addVec(0, 4'h0, 0, 0, 0,  1, 0, 4'h0, 1, 4'hA);
        addVec(0, 4'h0, 0, 0, 1,  1, 0, 4'h0, 1, 4'hA);
        // Fill OUT0, see backpressure only on sel=0, OUT1 still accepts.
        addVec(0, 4'h1, 1, 0, 0,  1, 0, 4'h0, 0, 4'h0);
        addVec(0, 4'h2, 1, 0, 0,  1, 1, 4'h1, 0, 4'h0);
        addVec(0, 4'h4, 1, 0, 0,  0, 1, 4'h1, 0, 4'h0);
        addVec(1, 4'h3, 1, 0, 0,  1, 1, 4'h1, 0, 4'h0);
        addVec(0, 4'h0, 0, 1, 0,  0, 1, 4'h1, 1, 4'h3);
        addVec(0, 4'h0, 0, 1, 0,  1, 1, 4'h2, 1, 4'h3);
        addVec(0, 4'h0, 0, 0, 1,  1, 0, 4'h0, 1, 4'h3);
        // Full FIFO popped while a push is offered: refused, then accepted.
        addVec(0, 4'h5, 1, 0, 0,  1, 0, 4'h0, 0, 4'h0);
        addVec(0, 4'h6, 1, 0, 0,  1, 1, 4'h5, 0, 4'h0);
        addVec(0, 4'h7, 1, 1, 0,  0, 1, 4'h5, 0, 4'h0);
        addVec(0, 4'h7, 1, 1, 0,  1, 1, 4'h6, 0, 4'h0);
        addVec(0, 4'h0, 0, 1, 0,  1, 1, 4'h7, 0, 4'h0);
        addVec(0, 4'h0, 0, 0, 0,  1, 0, 4'h0, 0, 4'h0);
        // Streaming 0..7 alternating destinations, both consumers ready.
        addVec(0, 4'h0, 1, 1, 1,  1, 0, 4'h0, 0, 4'h0);
        addVec(1, 4'h1, 1, 1, 1,  1, 1, 4'h0, 0, 4'h0);
        addVec(0, 4'h2, 1, 1, 1,  1, 0, 4'h0, 1, 4'h1);
        addVec(1, 4'h3, 1, 1, 1,  1, 1, 4'h2, 0, 4'h0);
        addVec(0, 4'h4, 1, 1, 1,  1, 0, 4'h0, 1, 4'h3);
        addVec(1, 4'h5, 1, 1, 1,  1, 1, 4'h4, 0, 4'h0);
        addVec(0, 4'h6, 1, 1, 1,  1, 0, 4'h0, 1, 4'h5);
        addVec(1, 4'h7, 1, 1, 1,  1, 1, 4'h6, 0, 4'h0);
        addVec(0, 4'h0, 0, 1, 1,  1, 0, 4'h0, 1, 4'h7);
        addVec(0, 4'h0, 0, 1, 1,  1, 0, 4'h0, 0, 4'h0);

        // Reset then idle.
        RST_N = 1'b0; IN_SEL = 1'b0; IN_DATA = '0; IN_VALID = 1'b0;
        OUT0_READY = 1'b0; OUT1_READY = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        #2;
        checkOutput("reset_sel0", 1, 0, 4'h0, 0, 4'h0);
        IN_SEL = 1'b1;
        #1;
        checkOutput("reset_sel1", 1, 0, 4'h0, 0, 4'h0);
`ifdef DEMUX_STATS_EN
        checkXfers("reset_xfers", 0, 0);
`endif

        // Table-driven body; expected pop counts derive from the table.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].sel, vecs[i].data, vecs[i].valid, vecs[i].r0, vecs[i].r1);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_v0, vecs[i].e_d0,
                        vecs[i].e_v1, vecs[i].e_d1);
            if (vecs[i].e_v0 && vecs[i].r0) exp_x0++;
            if (vecs[i].e_v1 && vecs[i].r1) exp_x1++;
        end

        // Reset mid-operation with data in both FIFOs.
        applyStimulus(0, 4'h8, 1, 0, 0);
        checkOutput("mid_push0", 1, 0, 4'h0, 0, 4'h0);
        applyStimulus(1, 4'h9, 1, 0, 0);
        checkOutput("mid_push1", 1, 1, 4'h8, 0, 4'h0);
        @(negedge CLK);
        IN_VALID = 1'b0; IN_SEL = 1'b0;
        #1;
        checkOutput("mid_loaded", 1, 1, 4'h8, 1, 4'h9);
`ifdef DEMUX_STATS_EN
        checkXfers("mid_xfers", exp_x0, exp_x1);
`endif
        #1;
        RST_N = 1'b0;
        #1;
        checkOutput("mid_async", 1, 0, 4'h0, 0, 4'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        #4;
        checkOutput("mid_release", 1, 0, 4'h0, 0, 4'h0);
`ifdef DEMUX_STATS_EN
        checkXfers("mid_xfers_cleared", 0, 0);
`endif
        applyStimulus(1, 4'h0, 0, 1, 1);
        checkOutput("mid_no_stale", 1, 0, 4'h0, 0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare);
        $finish;
    end

endmodule

// File: doc/demux122_stream.md
Name: demux122_stream

Overview:
Registered 1-to-2 stream demultiplexer with valid/ready handshaking. It routes each accepted input word to one of two destination streams, chosen per word by IN_SEL. Each destination has its own small FIFO, so one stalled consumer does not block words already queued for the other. It sits between a single producer (e.g. datapath result bus) and two consumers (e.g. register-file writeback and memory/IO staging) in the multicycle MCU.

Parameters:
WIDTH, 4, bit width of data words (in and out)
DEPTH, 2, entries per output FIFO; power of 2, >= 2

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous, active-low reset
IN_DATA  input  WIDTH  input word
IN_SEL  input  1  destination of IN_DATA: 0 -> OUT0, 1 -> OUT1
IN_VALID  input  1  producer presents a word
IN_READY  output  1  block can accept the word this cycle
OUT0_DATA  output  WIDTH  head word of FIFO 0
OUT0_VALID  output  1  FIFO 0 non-empty
OUT0_READY  input  1  consumer 0 takes head word
OUT1_DATA  output  WIDTH  head word of FIFO 1
OUT1_VALID  output  1  FIFO 1 non-empty
OUT1_READY  input  1  consumer 1 takes head word

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST_N. All state updates on the CLK rising edge.
- Reset values: both FIFO counts = 0, read/write pointers = 0, OUTx_VALID = 0, OUTx_DATA = 0. Storage contents are don't-care, but OUTx_DATA must read 0 while its FIFO is empty. Any words in flight are discarded when reset asserts mid-operation. IN_READY follows the (now empty) FIFO state combinationally.
- IN_READY (combinational) = NOT full(FIFO[IN_SEL]). It does not depend on IN_VALID.
- Full is evaluated on the registered count only. There is no same-cycle pass-through: a full FIFO being popped this cycle still deasserts IN_READY for that FIFO.
- Push: when IN_VALID && IN_READY, IN_DATA is written at wr_ptr[IN_SEL], that wr_ptr increments mod DEPTH, and count[IN_SEL] increments.
- Pop x: when OUTx_VALID && OUTx_READY, rd_ptr[x] increments mod DEPTH and count[x] decrements.
- Push and pop on the same FIFO in the same cycle: count unchanged, both pointers advance.
- Pushing to one FIFO never affects the other FIFO's state or outputs.
- OUTx_VALID = (count[x] != 0). OUTx_DATA = mem[x][rd_ptr[x]] (registered storage, combinational read).
- Latency: a word accepted in cycle N appears at OUTx in cycle N+1 if that FIFO was empty.
- Throughput: 1 word/cycle per output when its consumer holds READY high.
- Ordering: words to the same output leave in acceptance order. There is no ordering guarantee between OUT0 and OUT1.
- Count width is $clog2(DEPTH)+1. Pointers are $clog2(DEPTH) bits and wrap naturally.
- IN_SEL, IN_DATA and OUTx_READY are sampled only when their handshake fires. Changing IN_SEL while IN_VALID is held is legal: IN_READY re-evaluates for the new target.

Optional Feature:
Macro DEMUX_STATS_EN.
- Defined: adds output ports OUT0_XFERS and OUT1_XFERS (16 bits each). Each counts completed pops on its output, resets to 0, and wraps 0xFFFF -> 0x0000. A pop and a reset in the same cycle leaves the counter at 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset then idle: RST_N=0 for 2 cycles, release -> OUT0_VALID=OUT1_VALID=0, OUT0_DATA=OUT1_DATA=0, IN_READY=1 for both IN_SEL values.
- Single route (WIDTH=4, DEPTH=2): push 4'hA with IN_SEL=1, both READY=0 -> next cycle OUT1_VALID=1, OUT1_DATA=4'hA, OUT0_VALID=0.
- Fill and backpressure: push 4'h1, 4'h2 to OUT0 with OUT0_READY=0 -> IN_READY=0 when IN_SEL=0, IN_READY=1 when IN_SEL=1. Push 4'h3 to OUT1 -> accepted. Raise OUT0_READY -> OUT0 yields 1 then 2.
- Simultaneous push/pop at full: OUT0 full, OUT0_READY=1, IN_SEL=0, IN_VALID=1 -> IN_READY=0 that cycle, pop occurs. Next cycle IN_READY=1 and the push is accepted.
- Streaming and wrap: 8 alternating-destination words 0..7 with both READY=1 -> OUT0 gets 0,2,4,6 and OUT1 gets 1,3,5,7, each one cycle after acceptance, no stall, pointers wrap cleanly.
- Reset mid-operation: both FIFOs hold data, drop RST_N asynchronously between edges -> VALID outputs go 0 immediately. After release, no stale words appear. With DEMUX_STATS_EN, XFERS counters read 0.
